// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster counters with registered sync, active-video and line/frame strobes
module vga_timing_gen #(
  parameter int   H_ACTIVE = 800,
  parameter int   H_FP     = 56,
  parameter int   H_SYNC   = 120,
  parameter int   H_BP     = 64,
  parameter int   V_ACTIVE = 600,
  parameter int   V_FP     = 37,
  parameter int   V_SYNC   = 6,
  parameter int   V_BP     = 23,
  parameter logic HS_POL   = 1'b1,
  parameter logic VS_POL   = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pix_en,
  output logic [10:0] h_count,
  output logic [9:0]  v_count,
  output logic        hsync,
  output logic        vsync,
  output logic        video_on,
  output logic        line_end,
  output logic        frame_start
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST = 12'(V_TOTAL - 1);
  localparam logic [11:0] H_VIS  = 12'(H_ACTIVE);
  localparam logic [11:0] V_VIS  = 12'(V_ACTIVE);
  localparam logic [11:0] HS_BEG = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_END = 12'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [11:0] VS_BEG = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] VS_END = 12'(V_ACTIVE + V_FP + V_SYNC - 1);
  logic [11:0] h_nxt, v_nxt;
  logic        h_wrap;
  // flags decode the next-state counts so they land on the same edge as the counts
  always_comb begin
    h_wrap = {1'b0, h_count} == H_LAST;
    h_nxt  = h_wrap ? 12'd0 : {1'b0, h_count} + 12'd1;
    v_nxt  = !h_wrap ? {2'b0, v_count} : {2'b0, v_count} == V_LAST ? 12'd0 : {2'b0, v_count} + 12'd1;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      h_count     <= H_LAST[10:0];
      v_count     <= V_LAST[9:0];
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      video_on    <= 1'b0;
      line_end    <= 1'b0;
      frame_start <= 1'b0;
    end else if (pix_en) begin
      h_count     <= h_nxt[10:0];
      v_count     <= v_nxt[9:0];
      hsync       <= (h_nxt >= HS_BEG && h_nxt <= HS_END) ? HS_POL : ~HS_POL;
      vsync       <= (v_nxt >= VS_BEG && v_nxt <= VS_END) ? VS_POL : ~VS_POL;
      video_on    <= h_nxt < H_VIS && v_nxt < V_VIS;
      line_end    <= h_nxt == H_LAST;
      frame_start <= h_nxt == 12'd0 && v_nxt == 12'd0;
    end
  end
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: vector table, hand sequences and random pix_en against a position-index model
module tb_vga_timing_gen;
  typedef struct {int ha, hf, hs, hb, va, vf, vs, vb; bit hp, vp;} cfg_t;
  typedef struct packed {logic [10:0] h; logic [9:0] v; logic hs, vs, vo, le, fs;} obs_t;
  typedef struct {bit r, e; obs_t exp;} vec_t;
  logic clk = 0, reset = 1, pe0 = 0, pe1 = 0;
  logic [10:0] h0, h1;
  logic [9:0]  v0, v1;
  logic hs0, vs0, vo0, le0, fs0, hs1, vs1, vo1, le1, fs1;
  obs_t o0, o1;
  cfg_t cfg [2];
  int   pos [2], tot [2];
  bit   fresh [2];
  int   n_chk = 0, n_fail = 0;
  assign o0 = {h0, v0, hs0, vs0, vo0, le0, fs0};
  assign o1 = {h1, v1, hs1, vs1, vo1, le1, fs1};
  always #5 clk = ~clk;
  vga_timing_gen d0 (.clk(clk), .reset(reset), .pix_en(pe0), .h_count(h0), .v_count(v0),
    .hsync(hs0), .vsync(vs0), .video_on(vo0), .line_end(le0), .frame_start(fs0));
  vga_timing_gen #(.H_ACTIVE(10), .H_FP(2), .H_SYNC(3), .H_BP(2), .V_ACTIVE(5), .V_FP(1),
    .V_SYNC(2), .V_BP(1), .HS_POL(1'b0), .VS_POL(1'b0)) d1 (.clk(clk), .reset(reset),
    .pix_en(pe1), .h_count(h1), .v_count(v1), .hsync(hs1), .vsync(vs1), .video_on(vo1),
    .line_end(le1), .frame_start(fs1));
  // raster position is one linear index into the frame; reset parks it on the last pixel
  function automatic obs_t expect_of(cfg_t c, int p, bit f);
    int ht, h, v, hb, vb;
    obs_t o;
    ht = c.ha + c.hf + c.hs + c.hb;
    h = p % ht;
    v = p / ht;
    hb = c.ha + c.hf;
    vb = c.va + c.vf;
    o.h = 11'(h);
    o.v = 10'(v);
    o.hs = (!f && h >= hb && h < hb + c.hs) ? c.hp : ~c.hp;
    o.vs = (!f && v >= vb && v < vb + c.vs) ? c.vp : ~c.vp;
    o.vo = !f && h < c.ha && v < c.va;
    o.le = !f && h == ht - 1;
    o.fs = !f && p == 0;
    return o;
  endfunction
  task automatic check(string name, obs_t got, obs_t exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got h=%0d v=%0d hs=%b vs=%b vo=%b le=%b fs=%b, expected h=%0d v=%0d hs=%b vs=%b vo=%b le=%b fs=%b",
        name, got.h, got.v, got.hs, got.vs, got.vo, got.le, got.fs,
        exp.h, exp.v, exp.hs, exp.vs, exp.vo, exp.le, exp.fs);
    end
  endtask
  task automatic check_int(string name, int got, int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask
  task automatic cyc(input bit r, input bit e0, input bit e1);
    reset = r;
    pe0 = e0;
    pe1 = e1;
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (r) begin
        pos[i] = tot[i] - 1;
        fresh[i] = 1;
      end else if (i == 0 ? e0 : e1) begin
        pos[i] = (pos[i] + 1) % tot[i];
        fresh[i] = 0;
      end
    end
    @(negedge clk);
    check("d0 model", o0, expect_of(cfg[0], pos[0], fresh[0]));
    check("d1 model", o1, expect_of(cfg[1], pos[1], fresh[1]));
  endtask
  initial begin
    vec_t tbl [8];
    int n_hs, hs_first, n_le, le_h, off_h, enc, n_fs, n_vs, v_max, cnt;
    int fs_at [4];
    logic vs_prev;
    cfg[0] = '{800, 56, 120, 64, 600, 37, 6, 23, 1'b1, 1'b1};
    cfg[1] = '{10, 2, 3, 2, 5, 1, 2, 1, 1'b0, 1'b0};
    tot[0] = 1040 * 666;
    tot[1] = 17 * 9;
    tbl[0] = '{1, 1, {11'd1039, 10'd665, 5'b00000}};
    tbl[1] = '{0, 1, {11'd0,    10'd0,   5'b00101}};
    tbl[2] = '{0, 0, {11'd0,    10'd0,   5'b00101}};
    tbl[3] = '{0, 0, {11'd0,    10'd0,   5'b00101}};
    tbl[4] = '{0, 1, {11'd1,    10'd0,   5'b00100}};
    tbl[5] = '{0, 1, {11'd2,    10'd0,   5'b00100}};
    tbl[6] = '{1, 0, {11'd1039, 10'd665, 5'b00000}};
    tbl[7] = '{0, 1, {11'd0,    10'd0,   5'b00101}};
    for (int i = 0; i < 8; i++) begin
      cyc(tbl[i].r, tbl[i].e, tbl[i].e);
      check($sformatf("vec%0d", i), o0, tbl[i].exp);
    end
    check_int("d1 hsync idle high", int'(hs1), 1);
    check_int("d1 vsync idle high", int'(vs1), 1);
    // one full default line from (0,0)
    n_hs = 0; hs_first = -1; n_le = 0; le_h = -1; off_h = -1;
    for (int i = 0; i < 1040; i++) begin
      cyc(0, 1, 1'($urandom_range(0, 1)));
      if (hs0) begin
        n_hs++;
        if (hs_first < 0) hs_first = int'(h0);
      end
      if (le0) begin
        n_le++;
        le_h = int'(h0);
      end
      if (!vo0 && off_h < 0) off_h = int'(h0);
    end
    check_int("hsync width", n_hs, 120);
    check_int("hsync start", hs_first, 856);
    check_int("line_end count", n_le, 1);
    check_int("line_end h", le_h, 1039);
    check_int("video_on fall h", off_h, 800);
    check("line wrap", o0, {11'd0, 10'd1, 5'b00100});
    // reset in the middle of an hsync pulse
    for (int i = 0; i < 900; i++) cyc(0, 1, 1'($urandom_range(0, 1)));
    check_int("hsync active at 900", int'(hs0), 1);
    cyc(1, 0, 0);
    check("mid reset", o0, {11'd1039, 10'd665, 5'b00000});
    cyc(0, 1, 0);
    check("after mid reset", o0, {11'd0, 10'd0, 5'b00101});
    // small raster: whole frames under a random enable, bounded by a cycle budget
    cyc(1, 0, 0);
    enc = 0; n_fs = 0; n_vs = 0; v_max = 0; cnt = 0;
    vs_prev = vs1;
    while (n_fs < 4 && cnt < 2000) begin
      bit e;
      e = ($urandom_range(0, 3) != 0);
      cyc(0, 1'($urandom_range(0, 1)), e);
      cnt++;
      if (e) begin
        enc++;
        if (fs1) begin
          fs_at[n_fs] = enc;
          n_fs++;
        end
        if (n_fs >= 1 && n_fs < 4 && vs1 == 1'b0) n_vs++;
        if (int'(v1) > v_max) v_max = int'(v1);
      end
      if (vs1 != vs_prev) check_int("vsync edge at h=0", int'(h1), 0);
      vs_prev = vs1;
    end
    check_int("frame_start count", n_fs, 4);
    if (n_fs == 4) begin
      check_int("frame period 1", fs_at[1] - fs_at[0], 153);
      check_int("frame period 3", fs_at[3] - fs_at[2], 153);
    end
    check_int("vsync enabled cycles", n_vs, 3 * 34);
    check_int("v_count max", v_max, 8);
    // free-running random enables and occasional resets
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(0, 499) == 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
